// File: rtl/mw_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mw_writeback_stage
//  Description : M/W pipeline register with load-data formatter. Selects the
//                byte/half from the memory word, extends it, flags misaligned
//                loads and registers the writeback fields for the register
//                file and forwarding network.
//  Revision    : 1.0  initial release
// ============================================================================
module mw_writeback_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        flush,
  input  logic        M_valid,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_alu,
  input  logic [31:0] M_mem_read,
  input  logic [2:0]  M_width,
  input  logic [1:0]  M_wb_sel,
  input  logic        M_reg_we,
  input  logic [4:0]  M_reg_waddr,
  output logic        W_valid,
  output logic [31:0] W_PC,
  output logic        W_reg_we,
  output logic [4:0]  W_reg_waddr,
  output logic [31:0] W_wdata,
  output logic        W_misalign
);

  // Load format codes; anything not listed below behaves as lw.
  localparam logic [2:0] c_WIDTH_LH  = 3'd1;
  localparam logic [2:0] c_WIDTH_LHU = 3'd2;
  localparam logic [2:0] c_WIDTH_LB  = 3'd3;
  localparam logic [2:0] c_WIDTH_LBU = 3'd4;

  // Writeback source codes; code 3 falls back to the ALU result.
  localparam logic [1:0] c_WB_LOAD = 2'd1;
  localparam logic [1:0] c_WB_PC8  = 2'd2;

  logic [1:0]  w_offset;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_half;
  logic        w_is_byte;
  logic        w_is_word;
  logic [31:0] w_load;
  logic        w_misalign;

  logic        valid_d,    valid_q;
  logic [31:0] pc_d,       pc_q;
  logic        reg_we_d,   reg_we_q;
  logic [4:0]  waddr_d,    waddr_q;
  logic [31:0] wdata_d,    wdata_q;
  logic        misalign_d, misalign_q;

  assign w_offset  = M_alu[1:0];
  assign w_is_half = (M_width == c_WIDTH_LH) || (M_width == c_WIDTH_LHU);
  assign w_is_byte = (M_width == c_WIDTH_LB) || (M_width == c_WIDTH_LBU);
  assign w_is_word = ~w_is_half & ~w_is_byte;

  // Pick the addressed byte and half out of the aligned memory word.
  always_comb begin
    w_byte = M_mem_read[7:0];
    case (w_offset)
      2'd0: w_byte = M_mem_read[7:0];
      2'd1: w_byte = M_mem_read[15:8];
      2'd2: w_byte = M_mem_read[23:16];
      2'd3: w_byte = M_mem_read[31:24];
      default: w_byte = M_mem_read[7:0];
    endcase
    w_half = w_offset[1] ? M_mem_read[31:16] : M_mem_read[15:0];
  end

  // Extend the selected field into the final load value.
  always_comb begin
    w_load = M_mem_read;
    case (M_width)
      c_WIDTH_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      c_WIDTH_LBU: w_load = {24'd0, w_byte};
      c_WIDTH_LH:  w_load = {{16{w_half[15]}}, w_half};
      c_WIDTH_LHU: w_load = {16'd0, w_half};
      default:     w_load = M_mem_read;
    endcase
  end

  // Misalignment only matters for loads; bytes can never be misaligned.
  assign w_misalign = (M_wb_sel == c_WB_LOAD) &&
                      ((w_is_word && (w_offset != 2'd0)) ||
                       (w_is_half && w_offset[0]));

  // Next-state values for a normal capture.
  always_comb begin
    valid_d    = M_valid;
    pc_d       = M_PC;
    waddr_d    = M_reg_waddr;
    misalign_d = M_valid & w_misalign;
    reg_we_d   = M_valid & M_reg_we & (M_reg_waddr != 5'd0) & ~w_misalign;
    case (M_wb_sel)
      c_WB_LOAD: wdata_d = w_load;
      c_WB_PC8:  wdata_d = M_PC + 32'd8;
      default:   wdata_d = M_alu;
    endcase
  end

  // W register: reset/flush load a bubble, pause holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q    <= 1'b0;
      pc_q       <= PC_RESET;
      reg_we_q   <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else if (!pause) begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      reg_we_q   <= reg_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign W_valid     = valid_q;
  assign W_PC        = pc_q;
  assign W_reg_we    = reg_we_q;
  assign W_reg_waddr = waddr_q;
  assign W_wdata     = wdata_q;
  assign W_misalign  = misalign_q;

endmodule
`default_nettype wire

// File: doc/mw_writeback_stage.md
Name: mw_writeback_stage

Overview:
- M/W pipeline register plus load-data formatter; sits directly downstream of the data memory in the 5-stage pipeline.
- Captures memory-stage results on every clock edge and formats the raw 32-bit word read from memory into the final load value.
- Performs byte/half selection, sign/zero extension and alignment checking.
- Presents registered writeback data, destination register and write enable to the register file and the forwarding network.

Parameters:
- PC_RESET, 32'h0000_3000, value of W_PC after reset and when a bubble is inserted.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; applied on the clk posedge.
- pause  in  1  stall; W register holds its current value.
- flush  in  1  insert bubble into W.
- M_valid  in  1  M stage holds a real instruction.
- M_PC  in  32  PC of the M-stage instruction.
- M_alu  in  32  ALU result; also the data-memory byte address.
- M_mem_read  in  32  aligned word returned by data memory for M_alu[13:2].
- M_width  in  3  load format: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5-7 treated as lw.
- M_wb_sel  in  2  writeback source: 0 ALU, 1 load, 2 PC+8, 3 treated as ALU.
- M_reg_we  in  1  M-stage instruction writes a GPR.
- M_reg_waddr  in  5  destination GPR.
- W_valid  out  1  W holds a real instruction.
- W_PC  out  32  PC of the W instruction.
- W_reg_we  out  1  final GPR write enable.
- W_reg_waddr  out  5  destination GPR.
- W_wdata  out  32  writeback/forward data.
- W_misalign  out  1  W instruction was a misaligned load.

Behaviour:
- All outputs are registered. Latency is exactly 1 cycle from M inputs to W outputs.
- Update priority each posedge: reset > flush > pause > capture.
- Reset and flush load the bubble: W_valid=0, W_PC=PC_RESET, W_reg_we=0, W_reg_waddr=0, W_wdata=0, W_misalign=0.
- Flush asserted together with pause yields a bubble; flush wins.
- Pause with no flush: every W output holds its previous value. A load formatted while paused is discarded; nothing is captured.
- Capture: all W fields are computed combinationally from the M inputs and registered.
- Byte offset is a = M_alu[1:0].
- lb/lbu select M_mem_read[8a+7:8a]. lb sign-extends bit 7; lbu zero-extends.
- lh/lhu select M_mem_read[31:16] if a[1]=1, else M_mem_read[15:0]. lh sign-extends; lhu zero-extends.
- lw passes M_mem_read unchanged.
- Misalign when M_wb_sel=1 and either:
  - M_width is lw (including codes 5-7) and a!=0, or
  - M_width is lh/lhu and a[0]=1.
- Misalign is never flagged when M_wb_sel!=1.
- On misalign: W_misalign=1, W_reg_we=0. W_wdata is still the formatted value (lw: raw word; half: selected half), for debug only.
- W_wdata by M_wb_sel:
  - 0 and 3: M_alu.
  - 1: formatted load.
  - 2: M_PC+8, wrapping modulo 2^32.
- W_reg_we = M_valid & M_reg_we & (M_reg_waddr!=0) & ~misalign.
- W_reg_waddr = M_reg_waddr. It is captured even when W_reg_we=0; consumers must gate on W_reg_we.
- W_valid = M_valid; W_PC = M_PC.
- With M_valid=0, the remaining fields are still captured but W_reg_we=0 and W_misalign=0.
- Reset asserted mid-stream discards the in-flight W content. The first capture occurs on the first posedge with reset low, flush low and pause low.
- No internal combinational path from inputs to outputs.

Test Plan:
- Reset then idle: assert reset 2 cycles with random M inputs -> W_valid=0, W_PC=32'h0000_3000, W_reg_we=0, W_wdata=0, W_misalign=0.
- Byte loads, M_mem_read=32'h80FF_1234, wb_sel=1, valid=1, we=1, waddr=8:
  - lb @0x3 -> W_wdata=32'hFFFF_FF80.
  - lbu @0x1 -> 32'h0000_0012.
  - lb @0x0 -> 32'h0000_0034.
  - All three give W_reg_we=1.
- Half/word loads, same memory word:
  - lh @0x2 -> 32'hFFFF_80FF.
  - lhu @0x0 -> 32'h0000_1234.
  - lw @0x4 -> 32'h80FF_1234.
- Misalign:
  - lw @0x6 -> W_misalign=1, W_reg_we=0.
  - lh @0x1 -> W_misalign=1.
  - lb @0x1 -> W_misalign=0.
  - wb_sel=0 with M_alu=0x7 -> W_misalign=0.
- Sources and $0:
  - wb_sel=2, M_PC=0x0000_3000 -> W_wdata=0x0000_3008.
  - wb_sel=2, M_PC=0xFFFF_FFFC -> W_wdata=0x0000_0004.
  - waddr=0, we=1 -> W_reg_we=0.
- Stall/flush interplay:
  - Capture ALU 0x1234 to waddr 5.
  - Pause 3 cycles with changing inputs -> outputs frozen at 0x1234.
  - Pause+flush together -> bubble (W_valid=0).
  - Release -> next capture appears 1 cycle later.
